// File: rtl/x_ramb4_fifo_pkg.sv
// Shared sizing for the 4096x1 block-RAM FIFO controller.
package x_ramb4_fifo_pkg;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned ADDR_W = 12;
    // One extra bit above the address distinguishes full from empty.
    localparam int unsigned PTR_W  = 13;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Entries stored, given the write and read pointers.
    function automatic ptr_t fifo_count(input ptr_t wptr, input ptr_t rptr);
        return wptr - rptr;
    endfunction

endpackage

// File: rtl/x_fifo_ptr.sv
// Wrap-bit FIFO pointer: the low ADDR_W bits address the RAM and the top bit
// toggles each time the address rolls over from DEPTH-1 back to 0.
module x_fifo_ptr
    import x_ramb4_fifo_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    output ptr_t ptr_o
);

    ptr_t ptr_d;
    ptr_t ptr_q;

    // Next pointer: plain binary increment, the wrap bit falls out of the carry.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + ptr_t'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/x_ramb4_s1_fifo_ctrl.sv
// Synchronous FIFO controller driving an external 4096x1 dual-port block RAM.
// Port A writes, port B reads; read data appears one cycle after the read.
module x_ramb4_s1_fifo_ctrl
    import x_ramb4_fifo_pkg::*;
#(
    parameter int unsigned AFULL_THRESH  = 4088,
    parameter int unsigned AEMPTY_THRESH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic              DIN,
    output logic              FULL,
    output logic              AFULL,
    output logic              WR_OVF,
    input  logic              RD_EN,
    output logic              EMPTY,
    output logic              AEMPTY,
    output logic              RD_UDF,
    output logic              DOUT,
    output logic              DOUT_VALID,
    output logic [PTR_W-1:0]  COUNT,
    output logic [ADDR_W-1:0] RAM_ADDRA,
    output logic              RAM_ENA,
    output logic              RAM_WEA,
    output logic              RAM_DIA,
    output logic              RAM_RSTA,
    output logic [ADDR_W-1:0] RAM_ADDRB,
    output logic              RAM_ENB,
    output logic              RAM_WEB,
    output logic              RAM_RSTB,
    input  logic              RAM_DOB
);

    localparam ptr_t AfullThr  = PTR_W'(AFULL_THRESH);
    localparam ptr_t AemptyThr = PTR_W'(AEMPTY_THRESH);

    ptr_t wptr;
    ptr_t rptr;
    ptr_t count;
    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;

    logic dout_valid_d, dout_valid_q;
    logic wr_ovf_d, wr_ovf_q;
    logic rd_udf_d, rd_udf_q;

    x_fifo_ptr u_wptr (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (wr_accept),
        .ptr_o (wptr)
    );

    x_fifo_ptr u_rptr (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (rd_accept),
        .ptr_o (rptr)
    );

    // Status flags from registered pointers only; same-cycle requests never feed back.
    always_comb begin
        count     = fifo_count(wptr, rptr);
        full      = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
        empty     = (wptr == rptr);
        wr_accept = WR_EN && !full;
        rd_accept = RD_EN && !empty;
    end

    // RAM port drive; enables are forced low while reset is held.
    always_comb begin
        RAM_ENA   = wr_accept && !RST;
        RAM_WEA   = wr_accept && !RST;
        RAM_ADDRA = wptr[ADDR_W-1:0];
        RAM_DIA   = DIN;
        RAM_RSTA  = 1'b0;
        RAM_ENB   = rd_accept && !RST;
        RAM_ADDRB = rptr[ADDR_W-1:0];
        RAM_WEB   = 1'b0;
        RAM_RSTB  = 1'b0;
    end

    // Next state of the one-cycle flags.
    always_comb begin
        dout_valid_d = rd_accept;
        wr_ovf_d     = WR_EN && full;
        rd_udf_d     = RD_EN && empty;
    end

    // Flag registers; reset drops any read still in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_valid_q <= 1'b0;
            wr_ovf_q     <= 1'b0;
            rd_udf_q     <= 1'b0;
        end else begin
            dout_valid_q <= dout_valid_d;
            wr_ovf_q     <= wr_ovf_d;
            rd_udf_q     <= rd_udf_d;
        end
    end

    // Outputs.
    always_comb begin
        FULL       = full;
        EMPTY      = empty;
        COUNT      = count;
        AFULL      = (count >= AfullThr);
        AEMPTY     = (count <= AemptyThr);
        WR_OVF     = wr_ovf_q;
        RD_UDF     = rd_udf_q;
        DOUT_VALID = dout_valid_q;
        DOUT       = RAM_DOB;
    end

endmodule

// File: tb/tb_x_ramb4_s1_fifo_ctrl.sv
// Bench for x_ramb4_s1_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_x_ramb4_s1_fifo_ctrl;

    localparam int unsigned AfullThresh  = 4088;
    localparam int unsigned AemptyThresh = 8;
    localparam int          Depth        = 4096;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic        DIN = 1'b0;
    logic        RD_EN = 1'b0;
    logic        FULL, AFULL, WR_OVF, EMPTY, AEMPTY, RD_UDF, DOUT, DOUT_VALID;
    logic [12:0] COUNT;
    logic [11:0] RAM_ADDRA, RAM_ADDRB;
    logic        RAM_ENA, RAM_WEA, RAM_DIA, RAM_RSTA, RAM_ENB, RAM_WEB, RAM_RSTB;
    logic        RAM_DOB = 1'b0;

    x_ramb4_s1_fifo_ctrl #(
        .AFULL_THRESH  (AfullThresh),
        .AEMPTY_THRESH (AemptyThresh)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .DIN        (DIN),
        .FULL       (FULL),
        .AFULL      (AFULL),
        .WR_OVF     (WR_OVF),
        .RD_EN      (RD_EN),
        .EMPTY      (EMPTY),
        .AEMPTY     (AEMPTY),
        .RD_UDF     (RD_UDF),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .COUNT      (COUNT),
        .RAM_ADDRA  (RAM_ADDRA),
        .RAM_ENA    (RAM_ENA),
        .RAM_WEA    (RAM_WEA),
        .RAM_DIA    (RAM_DIA),
        .RAM_RSTA   (RAM_RSTA),
        .RAM_ADDRB  (RAM_ADDRB),
        .RAM_ENB    (RAM_ENB),
        .RAM_WEB    (RAM_WEB),
        .RAM_RSTB   (RAM_RSTB),
        .RAM_DOB    (RAM_DOB)
    );

    always #5 CLK = ~CLK;

    // 4096x1 dual-port RAM with a registered read port; contents survive reset.
    logic mem [0:Depth-1];
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB) RAM_DOB <= mem[RAM_ADDRB];
    end

    // Reference model state.
    bit q[$];
    int wcnt, rcnt;
    bit exp_valid, exp_dout, exp_ovf, exp_udf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1.
    task automatic step(input bit we, input bit din, input bit re);
        int cnt;
        bit full_m, empty_m, wa, ra;
        WR_EN = we;
        DIN   = din;
        RD_EN = re;
        @(negedge CLK);
        cnt     = q.size();
        full_m  = (cnt == Depth);
        empty_m = (cnt == 0);
        wa      = we && !full_m;
        ra      = re && !empty_m;
        check_eq("count", 32'(COUNT), 32'(cnt));
        check_eq("empty", 32'(EMPTY), 32'(empty_m));
        check_eq("full", 32'(FULL), 32'(full_m));
        check_eq("afull", 32'(AFULL), 32'(cnt >= int'(AfullThresh)));
        check_eq("aempty", 32'(AEMPTY), 32'(cnt <= int'(AemptyThresh)));
        check_eq("dout_valid", 32'(DOUT_VALID), 32'(exp_valid));
        if (exp_valid) check_eq("dout", 32'(DOUT), 32'(exp_dout));
        check_eq("wr_ovf", 32'(WR_OVF), 32'(exp_ovf));
        check_eq("rd_udf", 32'(RD_UDF), 32'(exp_udf));
        check_eq("ram_ena", 32'({RAM_ENA, RAM_WEA}), wa ? 32'd3 : 32'd0);
        check_eq("ram_enb", 32'(RAM_ENB), 32'(ra));
        if (wa) begin
            check_eq("ram_addra", 32'(RAM_ADDRA), 32'(wcnt % Depth));
            check_eq("ram_dia", 32'(RAM_DIA), 32'(din));
        end
        if (ra) check_eq("ram_addrb", 32'(RAM_ADDRB), 32'(rcnt % Depth));
        exp_ovf   = we && full_m;
        exp_udf   = re && empty_m;
        exp_valid = ra;
        if (ra) begin
            exp_dout = q.pop_front();
            rcnt++;
        end
        if (wa) begin
            q.push_back(din);
            wcnt++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset with requests held high; outputs must clear at once.
    task automatic do_reset();
        RST   = 1'b1;
        WR_EN = 1'b1;
        RD_EN = 1'b1;
        #1;
        check_eq("rst_count", 32'(COUNT), 32'd0);
        check_eq("rst_flags", 32'({EMPTY, AEMPTY, FULL, AFULL}), 32'b1100);
        check_eq("rst_pulses", 32'({DOUT_VALID, WR_OVF, RD_UDF}), 32'd0);
        check_eq("rst_ram_en", 32'({RAM_ENA, RAM_WEA, RAM_ENB}), 32'd0);
        check_eq("rst_ties", 32'({RAM_RSTA, RAM_WEB, RAM_RSTB}), 32'd0);
        @(posedge CLK);
        #1;
        check_eq("rst_hold_en", 32'({RAM_ENA, RAM_ENB, DOUT_VALID, WR_OVF}), 32'd0);
        @(negedge CLK);
        RST   = 1'b0;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        @(posedge CLK);
        #1;
        q.delete();
        wcnt      = 0;
        rcnt      = 0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    initial begin
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        @(posedge CLK);
        #1;
        do_reset();

        // Short write/read sequence.
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
        check_eq("four_written", 32'(COUNT), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Read while empty.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Fill to full, overflow once, then drain.
        for (int i = 0; i < Depth; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < Depth; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Steady state at ten entries with concurrent read and write.
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 5000; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        check_eq("steady_count", 32'(COUNT), 32'd10);

        // Random traffic with shifting bias.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = (i < 1000) ? 70 : ((i < 2000) ? 30 : 50);
            step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 50));
        end

        // Reset while a read is in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("valid_before_rst", 32'(DOUT_VALID), 32'd1);
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
